// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared RV32I register-file definitions used by the write-back front end:
// data/address widths, the write-back request record, the write-port source
// selector and a helper that turns a register address into a one-hot mask.
// ---------------------------------------------------------------------------
package rv32_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // Which producer owns the register-file write port in a given cycle.
   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_ALU,
      SRC_FIFO,
      SRC_BYPASS
   } wb_src_e;

   // One-hot mask of a register address; callers gate out x0 themselves.
   function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] r);
      logic [NUM_REGS-1:0] m;
      m    = '0;
      m[r] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Circular FIFO of write-back requests with wrap-around pointers.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (empties the FIFO)
//   push        enqueue push_data (ignored when full)
//   push_data   request to enqueue
//   pop         dequeue the head (ignored when empty)
//   pop_data    current head entry (valid while !empty)
//   full, empty occupancy flags
//   count       number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module wb_fifo
   import rv32_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  wb_req_t                  push_data,
   input  logic                     pop,
   output wb_req_t                  pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // DEPTH is a power of two, so the pointers wrap on their own.
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   wb_req_t       mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible through count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// rf_writeback_arbiter
// Merges ALU results (priority) and buffered LSU results onto the single
// register-file write port, with a starvation guard for the LSU queue and a
// pending-load scoreboard for decode.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data        single-cycle ALU result
//   alu_stall                        ALU result not taken; core must hold it
//   lsu_valid/lsu_ready/lsu_rd/lsu_data  LSU result handshake
//   ld_issue/ld_rd                   load issued this cycle and its target
//   rs1, rs2 / busy_rs1, busy_rs2    decode sources and their pending status
//   wb_we/wb_rd/wb_data              registered register-file write port
//   q_count                          LSU FIFO occupancy
// ---------------------------------------------------------------------------
module rf_writeback_arbiter
   import rv32_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [REG_ADDR_W-1:0]    alu_rd,
   input  logic [XLEN-1:0]          alu_data,
   output logic                     alu_stall,
   input  logic                     lsu_valid,
   output logic                     lsu_ready,
   input  logic [REG_ADDR_W-1:0]    lsu_rd,
   input  logic [XLEN-1:0]          lsu_data,
   input  logic                     ld_issue,
   input  logic [REG_ADDR_W-1:0]    ld_rd,
   input  logic [REG_ADDR_W-1:0]    rs1,
   input  logic [REG_ADDR_W-1:0]    rs2,
   output logic                     busy_rs1,
   output logic                     busy_rs2,
   output logic                     wb_we,
   output logic [REG_ADDR_W-1:0]    wb_rd,
   output logic [XLEN-1:0]          wb_data,
   output logic [$clog2(DEPTH):0]   q_count
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0]       starve;
   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic                fifo_full;
   logic                fifo_empty;
   logic                lsu_take;
   logic                starve_hit;
   logic                push;
   logic                pop;
   wb_req_t             head;
   wb_req_t             lsu_req;
   wb_req_t             grant;
   wb_src_e             src;

   assign lsu_req = '{rd: lsu_rd, data: lsu_data};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (lsu_req),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (q_count)
   );

   // Ready depends only on registered occupancy, never on this cycle's pop.
   assign lsu_ready  = !fifo_full;
   assign lsu_take   = lsu_valid && lsu_ready;
   assign starve_hit = (starve == SW'(STARVE_LIMIT)) && !fifo_empty;
   assign alu_stall  = starve_hit;

   always_comb begin
      src = SRC_NONE;
      if (starve_hit)
         src = SRC_FIFO;
      else if (alu_valid && (alu_rd != REG_ZERO))
         src = SRC_ALU;
      else if (!fifo_empty)
         src = SRC_FIFO;
      else if (lsu_take && (lsu_rd != REG_ZERO))
         src = SRC_BYPASS;
   end

   always_comb begin
      grant = '0;
      case (src)
         SRC_ALU:    grant = '{rd: alu_rd, data: alu_data};
         SRC_FIFO:   grant = head;
         SRC_BYPASS: grant = lsu_req;
         default:    grant = '0;
      endcase
   end

   assign pop = (src == SRC_FIFO);
   // x0 results complete the handshake but are never stored; a bypassed
   // result is written directly and must not also be queued.
   assign push = lsu_take && (lsu_rd != REG_ZERO) && (src != SRC_BYPASS);

   // Counts ALU wins against a waiting head; any pop or an empty queue
   // clears it. It cannot exceed STARVE_LIMIT because starve_hit preempts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         starve <= '0;
      else if (pop || fifo_empty)
         starve <= '0;
      else if (src == SRC_ALU)
         starve <= starve + 1'b1;
   end

   // A new load issue wins over the clear from a completing load.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (ld_issue && (ld_rd != REG_ZERO))
         set_mask = reg_mask(ld_rd);
      if ((src == SRC_FIFO) || (src == SRC_BYPASS))
         clr_mask = reg_mask(grant.rd);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pending <= '0;
      else
         pending <= (pending & ~clr_mask) | set_mask;
   end

   assign busy_rs1 = (rs1 != REG_ZERO) && pending[rs1];
   assign busy_rs2 = (rs2 != REG_ZERO) && pending[rs2];

   // Address and data hold when no write is granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_we   <= 1'b0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else begin
         wb_we <= (src != SRC_NONE);
         if (src != SRC_NONE) begin
            wb_rd   <= grant.rd;
            wb_data <= grant.data;
         end
      end
   end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_writeback_arbiter
// Directed bench for rf_writeback_arbiter with default parameters
// (DEPTH=4, STARVE_LIMIT=3).
// ---------------------------------------------------------------------------
module tb_rf_writeback_arbiter;

   logic        clk;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_stall;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        ld_issue;
   logic [4:0]  ld_rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        busy_rs1;
   logic        busy_rs2;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [2:0]  q_count;

   int compared;
   int mismatched;

   logic [31:0] tb_pend;

   rf_writeback_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_stall (alu_stall),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .ld_issue  (ld_issue),
      .ld_rd     (ld_rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .busy_rs1  (busy_rs1),
      .busy_rs2  (busy_rs2),
      .wb_we     (wb_we),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .q_count   (q_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Protocol checks against the bench's own record of outstanding loads.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         tb_pend <= '0;
      end else begin
         assert (!(alu_valid && alu_rd != 5'd0 && tb_pend[alu_rd]))
         else begin
            $display("FAIL proto_alu_to_pending rd=%0d got pending=1 want 0", alu_rd);
            mismatched++;
         end
         assert (!(ld_issue && ld_rd != 5'd0 && tb_pend[ld_rd] &&
                   !(lsu_valid && lsu_ready && lsu_rd == ld_rd)))
         else begin
            $display("FAIL proto_second_load rd=%0d got pending=1 want 0", ld_rd);
            mismatched++;
         end
         if (lsu_valid && lsu_ready && lsu_rd != 5'd0) tb_pend[lsu_rd] <= 1'b0;
         if (ld_issue && ld_rd != 5'd0) tb_pend[ld_rd] <= 1'b1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
      ld_issue = 0; ld_rd = 0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle_inputs();
      rs1 = 5'd5; rs2 = 5'd0;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      tick(); tick();
      compared++; if (wb_we !== 1'b0) begin mismatched++; $display("FAIL reset_wb_we got %0b want 0", wb_we); end
      compared++; if (wb_rd !== 5'd0) begin mismatched++; $display("FAIL reset_wb_rd got %0d want 0", wb_rd); end
      compared++; if (wb_data !== 32'd0) begin mismatched++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
      compared++; if (q_count !== 3'd0) begin mismatched++; $display("FAIL reset_q_count got %0d want 0", q_count); end
      compared++; if (lsu_ready !== 1'b1) begin mismatched++; $display("FAIL reset_lsu_ready got %0b want 1", lsu_ready); end
      compared++; if (alu_stall !== 1'b0) begin mismatched++; $display("FAIL reset_alu_stall got %0b want 0", alu_stall); end
      compared++; if (busy_rs1 !== 1'b0) begin mismatched++; $display("FAIL reset_busy_rs1 got %0b want 0", busy_rs1); end
      rst = 1'b0;
      tick();
      compared++; if (wb_we !== 1'b1) begin mismatched++; $display("FAIL first_alu_we got %0b want 1", wb_we); end
      compared++; if (wb_rd !== 5'd5) begin mismatched++; $display("FAIL first_alu_rd got %0d want 5", wb_rd); end
      compared++; if (wb_data !== 32'hDEADBEEF) begin mismatched++; $display("FAIL first_alu_data got %h want deadbeef", wb_data); end
      alu_valid = 1'b0;
      tick();
      compared++; if (wb_we !== 1'b0) begin mismatched++; $display("FAIL first_alu_pulse got %0b want 0", wb_we); end
      compared++; if (wb_rd !== 5'd5) begin mismatched++; $display("FAIL idle_hold_rd got %0d want 5", wb_rd); end
   endtask

   task automatic test_bypass;
      ld_issue = 1'b1; ld_rd = 5'd7;
      tick();
      ld_issue = 1'b0;
      rs1 = 5'd7;
      #1;
      compared++; if (busy_rs1 !== 1'b1) begin mismatched++; $display("FAIL bypass_busy_before got %0b want 1", busy_rs1); end
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h11;
      tick();
      lsu_valid = 1'b0;
      #1;
      compared++; if (wb_we !== 1'b1) begin mismatched++; $display("FAIL bypass_we got %0b want 1", wb_we); end
      compared++; if (wb_rd !== 5'd7) begin mismatched++; $display("FAIL bypass_rd got %0d want 7", wb_rd); end
      compared++; if (wb_data !== 32'h11) begin mismatched++; $display("FAIL bypass_data got %h want 11", wb_data); end
      compared++; if (q_count !== 3'd0) begin mismatched++; $display("FAIL bypass_q_count got %0d want 0", q_count); end
      compared++; if (busy_rs1 !== 1'b0) begin mismatched++; $display("FAIL bypass_pending_clr got %0b want 0", busy_rs1); end
      tick();
      compared++; if (wb_we !== 1'b0) begin mismatched++; $display("FAIL bypass_pulse got %0b want 0", wb_we); end
   endtask

   task automatic test_starve;
      int lrd [13];
      int e_q [13];
      int e_r [13];
      int e_s [13];
      int e_we[13];
      int e_rd[13];
      logic [31:0] exp_d;
      lrd  = '{10, 11, 12, 13, 14, 14, 0, 0, 0, 0, 0, 0, 0};
      e_q  = '{0, 1, 2, 3, 4, 3, 4, 4, 4, 3, 2, 1, 0};
      e_r  = '{1, 1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1};
      e_s  = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
      e_we = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      e_rd = '{3, 3, 3, 3, 10, 3, 3, 3, 11, 12, 13, 14, 0};
      for (int i = 0; i < 13; i++) begin
         alu_valid = (i <= 8); alu_rd = 5'd3; alu_data = 32'hA5;
         lsu_valid = (i <= 5); lsu_rd = 5'(lrd[i]); lsu_data = 32'h100 + 32'(lrd[i]) - 32'd10;
         #1;
         compared++; if (q_count !== 3'(e_q[i])) begin mismatched++; $display("FAIL starve_q_count c%0d got %0d want %0d", i, q_count, e_q[i]); end
         compared++; if (lsu_ready !== 1'(e_r[i])) begin mismatched++; $display("FAIL starve_lsu_ready c%0d got %0b want %0d", i, lsu_ready, e_r[i]); end
         compared++; if (alu_stall !== 1'(e_s[i])) begin mismatched++; $display("FAIL starve_alu_stall c%0d got %0b want %0d", i, alu_stall, e_s[i]); end
         tick();
         compared++; if (wb_we !== 1'(e_we[i])) begin mismatched++; $display("FAIL starve_wb_we c%0d got %0b want %0d", i, wb_we, e_we[i]); end
         if (e_we[i] == 1) begin
            exp_d = (e_rd[i] == 3) ? 32'hA5 : 32'h100 + 32'(e_rd[i]) - 32'd10;
            compared++; if (wb_rd !== 5'(e_rd[i])) begin mismatched++; $display("FAIL starve_wb_rd c%0d got %0d want %0d", i, wb_rd, e_rd[i]); end
            compared++; if (wb_data !== exp_d) begin mismatched++; $display("FAIL starve_wb_data c%0d got %h want %h", i, wb_data, exp_d); end
         end
      end
      idle_inputs();
   endtask

   task automatic test_scoreboard;
      ld_issue = 1'b1; ld_rd = 5'd9;
      tick();
      ld_issue = 1'b0;
      rs1 = 5'd9; rs2 = 5'd0;
      #1;
      compared++; if (busy_rs1 !== 1'b1) begin mismatched++; $display("FAIL sb_busy_set got %0b want 1", busy_rs1); end
      compared++; if (busy_rs2 !== 1'b0) begin mismatched++; $display("FAIL sb_busy_rs2_x0 got %0b want 0", busy_rs2); end
      tick();
      compared++; if (busy_rs1 !== 1'b1) begin mismatched++; $display("FAIL sb_busy_hold got %0b want 1", busy_rs1); end
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
      #1;
      compared++; if (busy_rs1 !== 1'b1) begin mismatched++; $display("FAIL sb_busy_at_grant got %0b want 1", busy_rs1); end
      tick();
      lsu_valid = 1'b0;
      #1;
      compared++; if (busy_rs1 !== 1'b0) begin mismatched++; $display("FAIL sb_busy_cleared got %0b want 0", busy_rs1); end
      compared++; if (wb_rd !== 5'd9) begin mismatched++; $display("FAIL sb_wb_rd got %0d want 9", wb_rd); end
      compared++; if (busy_rs2 !== 1'b0) begin mismatched++; $display("FAIL sb_busy_rs2_after got %0b want 0", busy_rs2); end
   endtask

   task automatic test_set_wins_and_x0;
      ld_issue = 1'b1; ld_rd = 5'd9;
      tick();
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h77;
      tick();
      ld_issue = 1'b0; lsu_valid = 1'b0;
      #1;
      compared++; if (busy_rs1 !== 1'b1) begin mismatched++; $display("FAIL set_wins_busy got %0b want 1", busy_rs1); end
      compared++; if (wb_we !== 1'b1 || wb_rd !== 5'd9) begin mismatched++; $display("FAIL set_wins_wb got we=%0b rd=%0d want we=1 rd=9", wb_we, wb_rd); end
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h78;
      tick();
      lsu_valid = 1'b0;
      #1;
      compared++; if (busy_rs1 !== 1'b0) begin mismatched++; $display("FAIL set_wins_reclear got %0b want 0", busy_rs1); end
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55;
      #1;
      compared++; if (lsu_ready !== 1'b1) begin mismatched++; $display("FAIL x0_lsu_ready got %0b want 1", lsu_ready); end
      tick();
      lsu_valid = 1'b0;
      #1;
      compared++; if (wb_we !== 1'b0) begin mismatched++; $display("FAIL x0_lsu_no_write got %0b want 0", wb_we); end
      compared++; if (q_count !== 3'd0) begin mismatched++; $display("FAIL x0_lsu_q_count got %0d want 0", q_count); end
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h66;
      tick();
      alu_valid = 1'b0;
      #1;
      compared++; if (wb_we !== 1'b0) begin mismatched++; $display("FAIL x0_alu_no_write got %0b want 0", wb_we); end
   endtask

   task automatic test_reset_mid;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hC3;
      ld_issue = 1'b1; ld_rd = 5'd25;
      lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h200;
      tick();
      ld_issue = 1'b0;
      lsu_rd = 5'd21; lsu_data = 32'h201;
      tick();
      lsu_rd = 5'd22; lsu_data = 32'h202;
      tick();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      rs1 = 5'd25;
      #1;
      compared++; if (q_count !== 3'd3) begin mismatched++; $display("FAIL mid_q_count_before got %0d want 3", q_count); end
      compared++; if (busy_rs1 !== 1'b1) begin mismatched++; $display("FAIL mid_busy_before got %0b want 1", busy_rs1); end
      compared++; if (wb_we !== 1'b1) begin mismatched++; $display("FAIL mid_we_before got %0b want 1", wb_we); end
      #1;
      rst = 1'b1;
      #1;
      compared++; if (q_count !== 3'd0) begin mismatched++; $display("FAIL mid_q_count_reset got %0d want 0", q_count); end
      compared++; if (wb_we !== 1'b0) begin mismatched++; $display("FAIL mid_we_reset got %0b want 0", wb_we); end
      compared++; if (busy_rs1 !== 1'b0) begin mismatched++; $display("FAIL mid_pending_reset got %0b want 0", busy_rs1); end
      compared++; if (lsu_ready !== 1'b1) begin mismatched++; $display("FAIL mid_lsu_ready_reset got %0b want 1", lsu_ready); end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         compared++; if (wb_we !== 1'b0) begin mismatched++; $display("FAIL mid_no_write c%0d got %0b want 0", i, wb_we); end
         compared++; if (q_count !== 3'd0) begin mismatched++; $display("FAIL mid_q_empty c%0d got %0d want 0", i, q_count); end
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_bypass();
      test_starve();
      test_scoreboard();
      test_set_wins_and_x0();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
Write-side front end for the 32x32 RV32I register file. It merges two result producers onto the register file's single write port (we, rd, data):
- single-cycle ALU results, which have priority;
- multi-cycle load/store results, buffered in a small FIFO.

It also keeps a pending-load scoreboard, so decode can stall on reads of registers whose load has not yet been written back.

Parameters:
DEPTH, 4, LSU result FIFO entries (power of 2, >=2)
STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO head may lose arbitration before the ALU is stalled

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
alu_valid  in  1  ALU result present this cycle
alu_rd  in  5  ALU destination register
alu_data  in  32  ALU result
alu_stall  out  1  ALU result not taken this cycle; core must hold it
lsu_valid  in  1  LSU result offered
lsu_ready  out  1  FIFO can accept
lsu_rd  in  5  LSU destination register
lsu_data  in  32  LSU result
ld_issue  in  1  load issued this cycle
ld_rd  in  5  destination of the issued load
rs1  in  5  decode source 1
rs2  in  5  decode source 2
busy_rs1  out  1  rs1 has a pending load
busy_rs2  out  1  rs2 has a pending load
wb_we  out  1  register file write enable
wb_rd  out  5  register file write address
wb_data  out  32  register file write data
q_count  out  3  FIFO occupancy (width clog2(DEPTH)+1)

Behaviour:
Reset
- rst (asynchronous, active-high, clock clk) clears all state immediately: wb_we=0, wb_rd=0, wb_data=0, FIFO empty, q_count=0, pending[31:0]=0, starve counter=0.
- Outputs while in and after reset: lsu_ready=1, alu_stall=0, busy_rs1=busy_rs2=0.
- rst mid-operation discards all queued results and pending bits; no write is issued.

Write-back outputs
- wb_we, wb_rd and wb_data are registered. The result chosen in cycle N appears on the outputs in cycle N+1, for exactly one cycle.

Grant order, evaluated each cycle
1. If starve counter == STARVE_LIMIT and the FIFO is non-empty: alu_stall=1, pop the FIFO head and write it. The ALU input is ignored.
2. Else if alu_valid and alu_rd!=0: write the ALU result. If the FIFO is non-empty, starve counter +1.
3. Else if the FIFO is non-empty: pop and write the head.
4. Else if an LSU result is accepted this cycle and its rd!=0: bypass it straight to the wb registers (not enqueued).
5. Else: wb_we=0 next cycle. wb_rd and wb_data hold their values.

Starve counter
- Resets to 0 whenever the FIFO is popped or the FIFO is empty.
- alu_stall is combinational from the counter and FIFO state.

Register 0
- Any result with rd==0 is dropped and never consumes the port.
- An LSU result with rd==0 is still accepted (handshake completes) but is not enqueued.

LSU handshake
- lsu_ready = (q_count < DEPTH), taken from registered state only.
- Transfer occurs when lsu_valid && lsu_ready.
- Enqueue and pop in the same cycle are allowed. q_count is unchanged when both occur.
- When full, lsu_ready=0 and no bypass happens.
- Producer holds lsu_rd and lsu_data stable while lsu_valid && !lsu_ready.

FIFO
- Circular with wrap-around pointers. In-order: pop order equals accept order.

Scoreboard
- ld_issue && ld_rd!=0 sets pending[ld_rd] on the next edge.
- A write-back issued from the LSU path (FIFO pop or bypass) clears pending[rd] on the edge it is granted.
- Simultaneous set and clear of the same rd: set wins.
- ALU writes never clear pending bits.
- busy_rsX = (rsX!=0) && pending[rsX], combinational.

Protocol requirements
- ALU write to a pending rd is illegal; decode stalls on busy.
- A second load to a pending rd is illegal.
- Both are checked by bench assertions.

Decomposition:
- Shared package rv32_pkg: XLEN=32, REG_ADDR_W=5, NUM_REGS=32, a wb_req struct {rd, data}, and the REG_ZERO constant.
- One sub-module, wb_fifo: parameterised DEPTH, carrying wb_req entries. It provides push/pop/full/empty/count and asynchronous reset.
- Arbitration, bypass, starve counter and scoreboard stay in rf_writeback_arbiter.

Test Plan:
1. Reset with alu_valid=1 (rd=5, data=0xDEADBEEF) -> release rst. Next cycle wb_we=1, wb_rd=5, wb_data=0xDEADBEEF; the cycle after, wb_we=0.
2. FIFO empty, no ALU, LSU push (rd=7, data=0x11) -> bypass: wb_we=1, wb_rd=7 one cycle later; q_count stays 0; pending[7] cleared.
3. ALU valid every cycle (rd=3) while LSU pushes 5 results -> after 4 pushes q_count=4 and lsu_ready=0. After STARVE_LIMIT=3 ALU grants, alu_stall=1 for one cycle and the head (first LSU rd) is written.
4. ld_issue rd=9, then rs1=9 -> busy_rs1=1 until the LSU write-back of rd=9 is granted; busy_rs1=0 on the following cycle. rs2=0 gives busy_rs2=0 always.
5. Same-cycle ld_issue rd=9 and LSU write-back of rd=9 -> pending[9] remains 1. LSU push with rd=0 -> accepted, q_count unchanged, no wb_we.
6. FIFO holding 3 entries, assert rst mid-stream -> q_count=0, wb_we=0, pending=0 at once. No further writes appear.
